// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic array host-side bus logic.
package systolic_array_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA,
        RESP
    } bus_init_state_t;

    typedef struct packed {
        logic  write;
        word_t addr;
        word_t wdata;
    } bus_cmd_t;

    typedef struct packed {
        logic  write;
        word_t rdata;
        logic  err;
    } bus_rsp_t;

endpackage

// File: rtl/bus_watchdog.sv
// Cycle watchdog: cleared on bus-phase entry, counts while enabled, and
// saturates so a late handshake on the last cycle cannot wrap it.
module bus_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding initiator: turns cmd/rsp handshakes into AW/W/AR/R
// channel transfers, with a watchdog that aborts a stalled responder.
module bus_initiator
    import systolic_array_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  cmd_valid,
    output logic  cmd_ready,
    input  logic  cmd_write,
    input  word_t cmd_addr,
    input  word_t cmd_wdata,
    output logic  rsp_valid,
    input  logic  rsp_ready,
    output logic  rsp_write,
    output word_t rsp_rdata,
    output logic  rsp_err,
    output logic  AWVALID,
    output word_t AWADDR,
    input  logic  AWREADY,
    output logic  WDVALID,
    output word_t WDATA,
    input  logic  WDREADY,
    output logic  ARVALID,
    output word_t ARADDR,
    input  logic  ARREADY,
    output logic  RDREADY,
    input  logic  RDVALID,
    input  word_t RDATA
);

    bus_init_state_t r_state, w_state_nx;
    logic     r_awvalid, r_wdvalid, r_arvalid, r_rdready, r_rsp_valid;
    logic     w_awvalid_nx, w_wdvalid_nx, w_arvalid_nx, w_rdready_nx, w_rsp_valid_nx;
    word_t    r_awaddr, r_wdata, r_araddr;
    word_t    w_awaddr_nx, w_wdata_nx, w_araddr_nx;
    bus_rsp_t r_rsp, w_rsp_nx;
    bus_cmd_t w_cmd;

    logic w_aw_done, w_w_done, w_wd_clear, w_wd_enable, w_expired;

    assign w_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    // A channel is done once its VALID has dropped or it handshakes now.
    assign w_aw_done = !r_awvalid || AWREADY;
    assign w_w_done  = !r_wdvalid || WDREADY;

    assign w_wd_clear  = (r_state == IDLE) && cmd_valid;
    assign w_wd_enable = (r_state == WRITE) || (r_state == RD_ADDR) || (r_state == RD_DATA);

    bus_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expired(w_expired)
    );

    // NOTE: every signal gets its hold value first so no path infers a latch.
    always_comb begin
        w_state_nx     = r_state;
        w_awvalid_nx   = r_awvalid;
        w_wdvalid_nx   = r_wdvalid;
        w_arvalid_nx   = r_arvalid;
        w_rdready_nx   = r_rdready;
        w_awaddr_nx    = r_awaddr;
        w_wdata_nx     = r_wdata;
        w_araddr_nx    = r_araddr;
        w_rsp_valid_nx = r_rsp_valid;
        w_rsp_nx       = r_rsp;
        unique case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    if (w_cmd.write) begin
                        w_state_nx   = WRITE;
                        w_awvalid_nx = 1'b1;
                        w_wdvalid_nx = 1'b1;
                        w_awaddr_nx  = w_cmd.addr;
                        w_wdata_nx   = w_cmd.wdata;
                    end else begin
                        w_state_nx   = RD_ADDR;
                        w_arvalid_nx = 1'b1;
                        w_araddr_nx  = w_cmd.addr;
                    end
                end
            end
            WRITE: begin
                if (AWREADY) w_awvalid_nx = 1'b0;
                if (WDREADY) w_wdvalid_nx = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_state_nx     = RESP;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_nx       = '{write: 1'b1, rdata: '0, err: 1'b0};
                end else if (w_expired) begin
                    w_state_nx     = RESP;
                    w_awvalid_nx   = 1'b0;
                    w_wdvalid_nx   = 1'b0;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_nx       = '{write: 1'b1, rdata: '0, err: 1'b1};
                end
            end
            RD_ADDR: begin
                if (ARREADY) begin
                    w_state_nx   = RD_DATA;
                    w_arvalid_nx = 1'b0;
                    w_rdready_nx = 1'b1;
                end else if (w_expired) begin
                    w_state_nx     = RESP;
                    w_arvalid_nx   = 1'b0;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_nx       = '{write: 1'b0, rdata: '0, err: 1'b1};
                end
            end
            RD_DATA: begin
                if (RDVALID) begin
                    w_state_nx     = RESP;
                    w_rdready_nx   = 1'b0;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_nx       = '{write: 1'b0, rdata: RDATA, err: 1'b0};
                end else if (w_expired) begin
                    w_state_nx     = RESP;
                    w_rdready_nx   = 1'b0;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_nx       = '{write: 1'b0, rdata: '0, err: 1'b1};
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nx     = IDLE;
                    w_rsp_valid_nx = 1'b0;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_awvalid   <= 1'b0;
            r_wdvalid   <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rdready   <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_araddr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_awvalid   <= w_awvalid_nx;
            r_wdvalid   <= w_wdvalid_nx;
            r_arvalid   <= w_arvalid_nx;
            r_rdready   <= w_rdready_nx;
            r_awaddr    <= w_awaddr_nx;
            r_wdata     <= w_wdata_nx;
            r_araddr    <= w_araddr_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp       <= w_rsp_nx;
        end
    end

    // Gated by rst so the command port reads not-ready throughout reset.
    assign cmd_ready = (r_state == IDLE) && !rst;
    assign AWVALID   = r_awvalid;
    assign AWADDR    = r_awaddr;
    assign WDVALID   = r_wdvalid;
    assign WDATA     = r_wdata;
    assign ARVALID   = r_arvalid;
    assign ARADDR    = r_araddr;
    assign RDREADY   = r_rdready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp.write;
    assign rsp_rdata = r_rsp.rdata;
    assign rsp_err   = r_rsp.err;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: a transaction-level model predicts every
// output each cycle, and literal checks pin the key cycles of each scenario.
module tb_bus_initiator;
    import systolic_array_pkg::*;

    localparam int TO = 8;

    logic  clk = 1'b0;
    logic  rst;
    logic  cmd_valid, cmd_ready, cmd_write;
    word_t cmd_addr, cmd_wdata;
    logic  rsp_valid, rsp_ready, rsp_write, rsp_err;
    word_t rsp_rdata;
    logic  AWVALID, AWREADY, WDVALID, WDREADY, ARVALID, ARREADY, RDREADY, RDVALID;
    word_t AWADDR, WDATA, ARADDR, RDATA;

    int n_checks = 0;
    int n_errors = 0;

    bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
        .WDVALID(WDVALID), .WDATA(WDATA), .WDREADY(WDREADY),
        .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
        .RDREADY(RDREADY), .RDVALID(RDVALID), .RDATA(RDATA)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level model ----------------
    logic  e_cmd_ready, e_awvalid, e_wdvalid, e_arvalid, e_rdready;
    logic  e_rsp_valid, e_rsp_write, e_rsp_err;
    word_t e_awaddr, e_wdata, e_araddr, e_rsp_rdata;

    task automatic m_clear();
        e_cmd_ready = 1'b1;
        e_awvalid   = 1'b0;
        e_wdvalid   = 1'b0;
        e_arvalid   = 1'b0;
        e_rdready   = 1'b0;
        e_rsp_valid = 1'b0;
        e_rsp_write = 1'b0;
        e_rsp_err   = 1'b0;
        e_rsp_rdata = '0;
        e_awaddr    = '0;
        e_wdata     = '0;
        e_araddr    = '0;
    endtask

    // Present a response and hold it until the consumer takes it.
    task automatic m_respond(input logic w, input word_t d, input logic err);
        e_rsp_valid = 1'b1;
        e_rsp_write = w;
        e_rsp_rdata = d;
        e_rsp_err   = err;
        forever begin
            @(posedge clk);
            if (rst) return;
            if (rsp_ready) begin
                e_rsp_valid = 1'b0;
                e_cmd_ready = 1'b1;
                return;
            end
        end
    endtask

    // n = cycles already spent on the bus for this command; abort on cycle TO-1.
    task automatic m_write(input word_t a, input word_t d);
        int   n = 0;
        logic aw_left = 1'b1;
        logic w_left = 1'b1;
        e_cmd_ready = 1'b0;
        e_awvalid   = 1'b1;
        e_wdvalid   = 1'b1;
        e_awaddr    = a;
        e_wdata     = d;
        forever begin
            @(posedge clk);
            if (rst) return;
            if (AWREADY) aw_left = 1'b0;
            if (WDREADY) w_left = 1'b0;
            if (!aw_left && !w_left) begin
                e_awvalid = 1'b0;
                e_wdvalid = 1'b0;
                m_respond(1'b1, '0, 1'b0);
                return;
            end
            if (n >= TO - 1) begin
                e_awvalid = 1'b0;
                e_wdvalid = 1'b0;
                m_respond(1'b1, '0, 1'b1);
                return;
            end
            e_awvalid = aw_left;
            e_wdvalid = w_left;
            n++;
        end
    endtask

    task automatic m_read(input word_t a);
        int   n = 0;
        logic addr_phase = 1'b1;
        e_cmd_ready = 1'b0;
        e_arvalid   = 1'b1;
        e_araddr    = a;
        forever begin
            @(posedge clk);
            if (rst) return;
            if (addr_phase) begin
                if (ARREADY) begin
                    addr_phase = 1'b0;
                    e_arvalid  = 1'b0;
                    e_rdready  = 1'b1;
                end else if (n >= TO - 1) begin
                    e_arvalid = 1'b0;
                    m_respond(1'b0, '0, 1'b1);
                    return;
                end
            end else begin
                if (RDVALID) begin
                    e_rdready = 1'b0;
                    m_respond(1'b0, RDATA, 1'b0);
                    return;
                end else if (n >= TO - 1) begin
                    e_rdready = 1'b0;
                    m_respond(1'b0, '0, 1'b1);
                    return;
                end
            end
            n++;
        end
    endtask

    initial begin : model
        m_clear();
        forever begin
            @(posedge clk);
            if (rst) begin
                m_clear();
            end else if (cmd_valid) begin
                if (cmd_write) m_write(cmd_addr, cmd_wdata);
                else           m_read(cmd_addr);
                if (rst) m_clear();
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_cmd_ready", 32'(cmd_ready), 32'(e_cmd_ready));
            check("m_awvalid",   32'(AWVALID),   32'(e_awvalid));
            check("m_wdvalid",   32'(WDVALID),   32'(e_wdvalid));
            check("m_arvalid",   32'(ARVALID),   32'(e_arvalid));
            check("m_rdready",   32'(RDREADY),   32'(e_rdready));
            check("m_rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
            if (e_awvalid) check("m_awaddr", AWADDR, e_awaddr);
            if (e_wdvalid) check("m_wdata",  WDATA,  e_wdata);
            if (e_arvalid) check("m_araddr", ARADDR, e_araddr);
            if (e_rsp_valid) begin
                check("m_rsp_write", 32'(rsp_write), 32'(e_rsp_write));
                check("m_rsp_rdata", rsp_rdata, e_rsp_rdata);
                check("m_rsp_err",   32'(rsp_err),   32'(e_rsp_err));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic w, input word_t a, input word_t d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin : stim
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        AWREADY = 1'b0; WDREADY = 1'b0; ARREADY = 1'b0; RDVALID = 1'b0; RDATA = '0;

        repeat (2) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_awvalid",   32'(AWVALID),   32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_awaddr",    AWADDR,         32'd0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write with readies tied high.
        AWREADY = 1'b1; WDREADY = 1'b1; rsp_ready = 1'b1;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        check("t1_cmd_ready_c0", 32'(cmd_ready), 32'd1);
        tick(); cmd_valid = 1'b0;
        check("t1_awvalid_c1", 32'(AWVALID), 32'd1);
        check("t1_wdvalid_c1", 32'(WDVALID), 32'd1);
        check("t1_awaddr_c1",  AWADDR, 32'h0000_0010);
        check("t1_wdata_c1",   WDATA,  32'hDEAD_BEEF);
        tick();
        check("t1_awvalid_c2",   32'(AWVALID),   32'd0);
        check("t1_rsp_valid_c2", 32'(rsp_valid), 32'd1);
        check("t1_rsp_write_c2", 32'(rsp_write), 32'd1);
        check("t1_rsp_err_c2",   32'(rsp_err),   32'd0);
        tick();
        check("t1_rsp_valid_c3", 32'(rsp_valid), 32'd0);
        check("t1_cmd_ready_c3", 32'(cmd_ready), 32'd1);
        AWREADY = 1'b0; WDREADY = 1'b0;

        // Write: WDREADY in cycle 1, AWREADY only in cycle 4.
        issue(1'b1, 32'h0000_0044, 32'hA5A5_0001);
        tick(); cmd_valid = 1'b0; WDREADY = 1'b1;
        tick(); WDREADY = 1'b0;
        check("t2_wdvalid_c2", 32'(WDVALID), 32'd0);
        check("t2_awvalid_c2", 32'(AWVALID), 32'd1);
        tick();
        check("t2_awaddr_c3", AWADDR, 32'h0000_0044);
        tick(); AWREADY = 1'b1;
        check("t2_awvalid_c4", 32'(AWVALID), 32'd1);
        tick(); AWREADY = 1'b0;
        check("t2_awvalid_c5",   32'(AWVALID),   32'd0);
        check("t2_rsp_valid_c5", 32'(rsp_valid), 32'd1);
        tick();
        check("t2_rsp_valid_c6", 32'(rsp_valid), 32'd0);

        // Read: ARREADY in cycle 2, RDVALID in cycle 5.
        issue(1'b0, 32'h0000_0020, '0);
        tick(); cmd_valid = 1'b0;
        check("t3_arvalid_c1", 32'(ARVALID), 32'd1);
        check("t3_araddr_c1",  ARADDR, 32'h0000_0020);
        tick(); ARREADY = 1'b1;
        tick(); ARREADY = 1'b0;
        check("t3_arvalid_c3", 32'(ARVALID), 32'd0);
        check("t3_rdready_c3", 32'(RDREADY), 32'd1);
        tick();
        tick(); RDVALID = 1'b1; RDATA = 32'h1234_5678;
        check("t3_rdready_c5", 32'(RDREADY), 32'd1);
        tick(); RDVALID = 1'b0; RDATA = '0;
        check("t3_rdready_c6",   32'(RDREADY),   32'd0);
        check("t3_rsp_valid_c6", 32'(rsp_valid), 32'd1);
        check("t3_rsp_rdata_c6", rsp_rdata, 32'h1234_5678);
        check("t3_rsp_err_c6",   32'(rsp_err),   32'd0);
        tick();

        // Read timeout: ARREADY never rises.
        issue(1'b0, 32'h0000_0030, '0);
        tick(); cmd_valid = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            check("t4_arvalid_held", 32'(ARVALID), 32'd1);
            tick();
        end
        check("t4_arvalid_abort", 32'(ARVALID),   32'd0);
        check("t4_rsp_valid",     32'(rsp_valid), 32'd1);
        check("t4_rsp_err",       32'(rsp_err),   32'd1);
        check("t4_rsp_rdata",     rsp_rdata,      32'd0);
        tick();
        check("t4_cmd_ready_after", 32'(cmd_ready), 32'd1);
        AWREADY = 1'b1; WDREADY = 1'b1;
        issue(1'b1, 32'h0000_0034, 32'h0000_00AA);
        tick(); cmd_valid = 1'b0;
        tick();
        check("t4_next_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t4_next_rsp_err",   32'(rsp_err),   32'd0);
        tick();
        AWREADY = 1'b0; WDREADY = 1'b0;

        // Read whose data arrives on the last watchdog cycle: completes normally.
        issue(1'b0, 32'h0000_0038, '0);
        tick(); cmd_valid = 1'b0; ARREADY = 1'b1;
        tick(); ARREADY = 1'b0;
        repeat (TO - 2) tick();
        RDVALID = 1'b1; RDATA = 32'h0BAD_F00D;
        tick(); RDVALID = 1'b0; RDATA = '0;
        check("t4b_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t4b_rsp_err",   32'(rsp_err),   32'd0);
        check("t4b_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        tick();

        // Write timeout: W completes in cycle 1, AW never does.
        issue(1'b1, 32'h0000_003C, 32'h0000_0055);
        tick(); cmd_valid = 1'b0; WDREADY = 1'b1;
        tick(); WDREADY = 1'b0;
        repeat (TO - 1) tick();
        check("t4c_awvalid", 32'(AWVALID),   32'd0);
        check("t4c_rsp_err", 32'(rsp_err),   32'd1);
        check("t4c_rsp_wr",  32'(rsp_write), 32'd1);
        tick();

        // Response back-pressure with a second command waiting.
        AWREADY = 1'b1; WDREADY = 1'b1; ARREADY = 1'b1; rsp_ready = 1'b0;
        issue(1'b1, 32'h0000_0050, 32'h1111_2222);
        tick(); issue(1'b0, 32'h0000_0060, '0);
        tick();
        for (int i = 2; i <= 6; i++) begin
            check("t5_cmd_ready_held", 32'(cmd_ready), 32'd0);
            check("t5_rsp_valid_held", 32'(rsp_valid), 32'd1);
            check("t5_rsp_write_held", 32'(rsp_write), 32'd1);
            check("t5_arvalid_none",   32'(ARVALID),   32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        check("t5_rsp_valid_c7", 32'(rsp_valid), 32'd1);
        tick();
        check("t5_cmd_ready_c8", 32'(cmd_ready), 32'd1);
        check("t5_rsp_valid_c8", 32'(rsp_valid), 32'd0);
        tick(); cmd_valid = 1'b0; RDVALID = 1'b1; RDATA = 32'h0000_0077;
        check("t5_arvalid_c9", 32'(ARVALID), 32'd1);
        check("t5_araddr_c9",  ARADDR, 32'h0000_0060);
        tick();
        tick(); RDVALID = 1'b0; RDATA = '0;
        check("t5_rsp_rdata", rsp_rdata, 32'h0000_0077);
        tick();
        AWREADY = 1'b0; WDREADY = 1'b0; ARREADY = 1'b0;

        // Reset in the middle of a stalled write.
        issue(1'b1, 32'h0000_0070, 32'h0000_0099);
        tick(); cmd_valid = 1'b0;
        tick();
        check("t6_awvalid_pre", 32'(AWVALID), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_awvalid_rst",   32'(AWVALID),   32'd0);
        check("t6_wdvalid_rst",   32'(WDVALID),   32'd0);
        check("t6_awaddr_rst",    AWADDR,         32'd0);
        check("t6_wdata_rst",     WDATA,          32'd0);
        check("t6_cmd_ready_rst", 32'(cmd_ready), 32'd0);
        check("t6_rsp_valid_rst", 32'(rsp_valid), 32'd0);
        tick();
        tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_cmd_ready_post", 32'(cmd_ready), 32'd1);
            check("t6_rsp_valid_post", 32'(rsp_valid), 32'd0);
            check("t6_awvalid_post",   32'(AWVALID),   32'd0);
        end
        ARREADY = 1'b1; RDVALID = 1'b1; RDATA = 32'h0000_5A5A;
        issue(1'b0, 32'h0000_0080, '0);
        tick(); cmd_valid = 1'b0;
        tick();
        tick();
        check("t6_read_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t6_read_rsp_rdata", rsp_rdata, 32'h0000_5A5A);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Host-side initiator for the systolic array's register/scratchpad bus. It accepts single-beat read or write commands on a valid/ready command port and drives the accelerator's AW/W/AR/R channels (AWVALID/AWADDR, WDVALID/WDATA, ARVALID/ARADDR, RDREADY/RDVALID/RDATA). It returns one response per command and aborts with an error flag if the responder stalls past a watchdog limit. It sits between test/host logic and the accelerator's slave port, and is used both in integration benches and in any on-chip host wrapper.

## Interface
- TIMEOUT_CYCLES, 1024, max cycles spent in any bus state before abort (≥2)
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  target address (word_t)
- cmd_wdata  in  32  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both high
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  command aborted by watchdog
- AWVALID / AWADDR  out  1 / 32  write address channel
- AWREADY  in  1
- WDVALID / WDATA  out  1 / 32  write data channel
- WDREADY  in  1
- ARVALID / ARADDR  out  1 / 32  read address channel
- ARREADY  in  1
- RDREADY  out  1  initiator ready for read data
- RDVALID / RDATA  in  1 / 32  read data channel

## Operation
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA, RESP.
- IDLE: cmd_ready=1. On handshake, latch command; write → WRITE (AWVALID=WDVALID=1), read → RD_ADDR (ARVALID=1).
- WRITE: AW and W are independent. Each VALID drops the cycle after its own handshake; aw_done/w_done flags are tracked. Both done (including same cycle) → RESP with rsp_write=1, rsp_rdata=0.
- RD_ADDR: ARVALID held until ARREADY, then → RD_DATA.
- RD_DATA: RDREADY=1. On RDVALID, capture RDATA → RESP with rsp_write=0.
- RESP: rsp_valid=1 with stable payload until rsp_ready, then → IDLE. cmd_ready=0 outside IDLE: one outstanding command only.
- Valid rule: an asserted AWVALID/WDVALID/ARVALID never drops before its ready, except on watchdog abort. Address and data stay stable while valid.
- Watchdog: counter clears on entry to WRITE/RD_ADDR and increments each cycle in WRITE/RD_ADDR/RD_DATA. It does not clear between RD_ADDR and RD_DATA. When it reaches TIMEOUT_CYCLES-1 without completion, all bus VALIDs and RDREADY deassert next cycle → RESP with rsp_err=1, rsp_rdata=0. A handshake in the abort cycle wins (normal completion). The watchdog never runs in RESP.
- Reset mid-transaction: everything returns to IDLE immediately; any partial bus transfer is abandoned.

## Timing
- Reset values: cmd_ready=0 while rst high, 1 in IDLE after release; all other outputs 0 (rsp_*, *VALID, RDREADY, addresses, WDATA).
- All outputs registered except cmd_ready, which is decoded from state.
- Write with AWREADY=WDREADY=1: cmd handshake cycle 0, VALIDs high cycle 1, rsp_valid cycle 2.
- Read with ARREADY=1 and RDVALID tied 1: ARVALID cycle 1, RDREADY cycle 2, rsp_valid cycle 3 carrying the cycle-2 RDATA.
- Next command is acceptable the cycle after the response handshake (min 3-cycle write, 4-cycle read throughput).

## Structure
- Shared package (systolic_array_pkg): word_t (existing), bus_init_state_t enum, bus_cmd_t struct {write, addr, wdata}, bus_rsp_t struct {write, rdata, err}.
- One sub-module: bus_watchdog (clear, enable, parameter LIMIT, output expired).

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF, readies tied 1 → AWVALID/WDVALID high exactly cycle 1, rsp_valid cycle 2, rsp_write=1, rsp_err=0.
- Write with AWREADY delayed 3 cycles, WDREADY at cycle 1 → WDVALID drops cycle 2, AWVALID held with stable AWADDR until cycle 4, single response after.
- Read 0x0000_0020, ARREADY at cycle 2, RDVALID at cycle 5 with RDATA=0x1234_5678 → RDREADY high cycles 3–5, rsp_rdata=0x1234_5678, rsp_err=0.
- TIMEOUT_CYCLES=8, read with ARREADY never high → ARVALID drops after 8 cycles, rsp_err=1, rsp_rdata=0; next command then accepted normally.
- rsp_ready held 0 for 5 cycles → rsp payload stable, cmd_ready=0 throughout, and a second cmd_valid is not accepted until after the response handshake.
- rst asserted mid-WRITE (AWREADY low) → all outputs 0 asynchronously, IDLE after release, no stale response.
